// File: rtl/arrow_judge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : arrow_judge
//  Description : Player-input judge for the dance game. Synchronizes and
//                debounces the four arrow buttons, collects the presses made
//                between metronome beats and judges each beat's presses
//                against the requested arrow. Produces the running score,
//                the combo count and one-cycle hit/miss pulses.
//
//  Ports       : clk            system clock (single domain)
//                rst_n          asynchronous active-low reset
//                metronome_clk  beat clock, asynchronous to clk
//                state          game state (STATE_GAME / STATE_PAUSE / other)
//                cur_arrow3     arrow code to hit, sampled on the beat cycle
//                btn[3:0]       raw buttons {up,down,left,right}, active-high
//                score          running score, saturates at SCORE_MAX
//                comboCount     consecutive hits, saturates at SCORE_MAX
//                hit / miss     one-cycle judgement pulses
//
//  Options     : `define ARROW_JUDGE_COMBO_BONUS_EN -> a hit adds 2 to the
//                score while comboCount (before increment) is >= 10.
//
//  Parameters  : STATE_BITS, NUM_ARROWS_BITS, STATE_GAME and STATE_PAUSE
//                default to the ddr_definitions.v values.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module arrow_judge #(
  parameter int                   STATE_BITS      = 2,
  parameter int                   NUM_ARROWS_BITS = 4,
  parameter logic [STATE_BITS:0]  STATE_GAME      = (STATE_BITS+1)'(1),
  parameter logic [STATE_BITS:0]  STATE_PAUSE     = (STATE_BITS+1)'(2),
  parameter int                   DEBOUNCE_CYCLES = 250000,
  parameter int                   SCORE_MAX       = 9999
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       metronome_clk,
  input  logic [STATE_BITS:0]        state,
  input  logic [NUM_ARROWS_BITS:0]   cur_arrow3,
  input  logic [3:0]                 btn,
  output logic [13:0]                score,
  output logic [13:0]                comboCount,
  output logic                       hit,
  output logic                       miss
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_WINDOW = 2'd2;
  localparam logic [1:0] S_JUDGE  = 2'd3;

  // --------------------------------------------------------------------------
  // Input synchronizers, beat detect, press-edge detect
  // --------------------------------------------------------------------------
  logic [3:0]          btn_meta_q, btn_sync_q, deb_prev_q;
  logic [2:0]          metro_q;
  logic [STATE_BITS:0] prev_state_q;
  logic [3:0]          w_deb_level;
  logic [3:0]          w_press;
  logic                w_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      deb_prev_q   <= '0;
      metro_q      <= '0;
      prev_state_q <= '0;
    end else begin
      btn_meta_q   <= btn;
      btn_sync_q   <= btn_meta_q;
      deb_prev_q   <= w_deb_level;
      // Newest sample enters at bit 2; bits 1/0 are the older samples.
      metro_q      <= {metronome_clk, metro_q[2:1]};
      prev_state_q <= state;
    end
  end

  // Rising edge seen between the two oldest samples of the metronome.
  assign w_beat  = ~metro_q[0] & metro_q[1];
  assign w_press = w_deb_level & ~deb_prev_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any return to the old level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else if (btn_sync_q[gi] == level_q) begin
        cnt_q   <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= btn_sync_q[gi];
      end else begin
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end

    assign w_deb_level[gi] = level_q;
  end

  // --------------------------------------------------------------------------
  // Arrow code -> required button mask {up,down,left,right}
  // --------------------------------------------------------------------------
  function automatic logic [3:0] arrow_mask(input logic [NUM_ARROWS_BITS:0] code);
    logic [3:0] m;
    case (int'(code))
      10:      m = 4'b1000;
      11:      m = 4'b0100;
      12:      m = 4'b0010;
      13:      m = 4'b0001;
      14:      m = 4'b1100;
      15:      m = 4'b1010;
      16:      m = 4'b1001;
      17:      m = 4'b0110;
      18:      m = 4'b0101;
      19:      m = 4'b0011;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // --------------------------------------------------------------------------
  // Judge FSM and score keeping
  // --------------------------------------------------------------------------
  logic [1:0]  fsm_q, fsm_d;
  logic [3:0]  target_q, target_d;
  logic [3:0]  press_mask_q, press_mask_d;
  logic [13:0] score_q, score_d;
  logic [13:0] combo_q, combo_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;

  logic [1:0]  w_inc;
  logic [14:0] w_score_sum, w_combo_sum;
  logic [13:0] w_score_sat, w_combo_sat;

`ifdef ARROW_JUDGE_COMBO_BONUS_EN
  assign w_inc = (combo_q >= 14'd10) ? 2'd2 : 2'd1;
`else
  assign w_inc = 2'd1;
`endif

  assign w_score_sum = {1'b0, score_q} + {13'd0, w_inc};
  assign w_combo_sum = {1'b0, combo_q} + 15'd1;
  assign w_score_sat = (w_score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_score_sum[13:0];
  assign w_combo_sat = (w_combo_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_combo_sum[13:0];

  // The judgement is resolved on the beat cycle so the registered pulse and
  // the updated score appear together one clk later, during S_JUDGE. A press
  // landing on the beat cycle seeds the next window's mask.
  always_comb begin
    fsm_d        = fsm_q;
    target_d     = target_q;
    press_mask_d = press_mask_q;
    score_d      = score_q;
    combo_d      = combo_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;

    if (state != STATE_GAME) begin
      fsm_d        = S_IDLE;
      press_mask_d = '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          fsm_d        = S_ARM;
          press_mask_d = '0;
          // Resuming from pause keeps the running totals; a fresh game resets.
          if (prev_state_q != STATE_PAUSE) begin
            score_d = '0;
            combo_d = '0;
          end
        end
        S_ARM: begin
          press_mask_d = '0;
          if (w_beat) begin
            target_d = arrow_mask(cur_arrow3);
            fsm_d    = S_WINDOW;
          end
        end
        S_WINDOW: begin
          if (w_beat) begin
            if (press_mask_q == target_q) begin
              hit_d   = 1'b1;
              score_d = w_score_sat;
              combo_d = w_combo_sat;
            end else begin
              miss_d  = 1'b1;
              combo_d = '0;
            end
            target_d     = arrow_mask(cur_arrow3);
            press_mask_d = w_press;
            fsm_d        = S_JUDGE;
          end else begin
            press_mask_d = press_mask_q | w_press;
          end
        end
        default: begin  // S_JUDGE: pulse cycle, new window already collecting
          press_mask_d = press_mask_q | w_press;
          fsm_d        = S_WINDOW;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      target_q     <= '0;
      press_mask_q <= '0;
      score_q      <= '0;
      combo_q      <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      target_q     <= target_d;
      press_mask_q <= press_mask_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign score      = score_q;
  assign comboCount = combo_q;
  assign hit        = hit_q;
  assign miss       = miss_q;

endmodule
`default_nettype wire
